// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: register file geometry and types.
package mips_pkg;

  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

endpackage : mips_pkg

// File: rtl/regfile_read_port.sv
// One combinational read port of the register file.
// Zero-register override always applies. Write-to-read forwarding of the
// in-flight write is compiled in when REGFILE_BYPASS_EN is defined.
module regfile_read_port
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
  input  logic [ADDR_W-1:0] addr,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] data
);

`ifdef REGFILE_BYPASS_EN
  logic bypass_hit;

  // Forward the pending write when it targets this port's (nonzero) index.
  always_comb begin
    bypass_hit = 1'b0;
    if (!rst && wr_en && (wr_addr != '0) && (wr_addr == addr)) begin
      bypass_hit = 1'b1;
    end
  end
`else
  // Write-side inputs are only consumed by the forwarding path.
  logic unused_wr;
  assign unused_wr = ^{rst, wr_en, wr_addr, wr_data};
`endif

  // Read mux with index 0 forced to zero.
  always_comb begin
    data = regs[addr];
`ifdef REGFILE_BYPASS_EN
    if (bypass_hit) begin
      data = wr_data;
    end
`endif
    if (addr == '0) begin
      data = '0;
    end
  end

endmodule : regfile_read_port

// File: rtl/register_file.sv
// 2^ADDR_W x DATA_W MIPS register file: two combinational read ports, one
// clocked write port, register 0 hardwired to zero, asynchronous reset.
// Optional same-cycle write forwarding: define REGFILE_BYPASS_EN.
module register_file
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] read_reg_1,
  input  logic [ADDR_W-1:0] read_reg_2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] out_data_1,
  output logic [DATA_W-1:0] out_data_2
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  // Storage: async clear, write on rising edge unless targeting index 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (RegWrite && (write_reg != '0)) begin
      regs[write_reg] <= write_data;
    end
  end

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_port_1 (
    .regs    (regs),
    .addr    (read_reg_1),
    .rst     (rst),
    .wr_en   (RegWrite),
    .wr_addr (write_reg),
    .wr_data (write_data),
    .data    (out_data_1)
  );

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_port_2 (
    .regs    (regs),
    .addr    (read_reg_2),
    .rst     (rst),
    .wr_en   (RegWrite),
    .wr_addr (write_reg),
    .wr_data (write_data),
    .data    (out_data_2)
  );

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed, table-driven bench for register_file (either build of
// REGFILE_BYPASS_EN), plus hand sequences for forwarding and async reset.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic        RegWrite;
  logic [4:0]  read_reg_1;
  logic [4:0]  read_reg_2;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] out_data_1;
  logic [31:0] out_data_2;

  int tests_run;
  int tests_failed;

  register_file dut (
    .clk        (clk),
    .rst        (rst),
    .RegWrite   (RegWrite),
    .read_reg_1 (read_reg_1),
    .read_reg_2 (read_reg_2),
    .write_reg  (write_reg),
    .write_data (write_data),
    .out_data_1 (out_data_1),
    .out_data_2 (out_data_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  localparam int NVEC = 9;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [31:0] exp_pre;

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    // {we, write_reg, write_data, read_reg_1, read_reg_2, exp_1, exp_2}
    vecs = '{
      '{1'b0, 5'd0,  32'd0,         5'd2,  5'd5,  32'd0,         32'd0},
      '{1'b1, 5'd2,  32'd25,        5'd2,  5'd5,  32'd25,        32'd0},
      '{1'b1, 5'd5,  32'd25,        5'd2,  5'd5,  32'd25,        32'd25},
      '{1'b1, 5'd0,  32'hDEADBEEF,  5'd0,  5'd0,  32'd0,         32'd0},
      '{1'b0, 5'd2,  32'd99,        5'd2,  5'd2,  32'd25,        32'd25},
      '{1'b1, 5'd31, 32'hFFFFFFFF,  5'd31, 5'd5,  32'hFFFFFFFF,  32'd25},
      '{1'b1, 5'd1,  32'hA5A5A5A5,  5'd1,  5'd31, 32'hA5A5A5A5,  32'hFFFFFFFF},
      '{1'b1, 5'd2,  32'h12345678,  5'd2,  5'd2,  32'h12345678,  32'h12345678},
      '{1'b1, 5'd7,  32'd3,         5'd7,  5'd0,  32'd3,         32'd0}
    };

    rst        = 1'b1;
    RegWrite   = 1'b0;
    read_reg_1 = 5'd2;
    read_reg_2 = 5'd5;
    write_reg  = 5'd0;
    write_data = 32'd0;

    #12;
    check("reset_out1", out_data_1, 32'd0);
    check("reset_out2", out_data_2, 32'd0);
    rst = 1'b0;

    // Table: drive between edges, read back just after the edge with writes off.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      RegWrite   = vecs[i].we;
      write_reg  = vecs[i].wr;
      write_data = vecs[i].wd;
      read_reg_1 = vecs[i].r1;
      read_reg_2 = vecs[i].r2;
      @(posedge clk);
      #1;
      RegWrite = 1'b0;
      #1;
      check($sformatf("vec%0d_out1", i), out_data_1, vecs[i].e1);
      check($sformatf("vec%0d_out2", i), out_data_2, vecs[i].e2);
    end

    // Pending write of 8 to reg 7 (holds 3): forwarded only in the bypass build.
    @(negedge clk);
    read_reg_1 = 5'd7;
    read_reg_2 = 5'd0;
    RegWrite   = 1'b1;
    write_reg  = 5'd7;
    write_data = 32'd8;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_pre = 32'd8;
`else
    exp_pre = 32'd3;
`endif
    check("pending_w7_out1", out_data_1, exp_pre);
    check("pending_w7_zero", out_data_2, 32'd0);
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    #1;
    check("after_w7_out1", out_data_1, 32'd8);

    // Pending write to index 0 never forwards.
    @(negedge clk);
    RegWrite   = 1'b1;
    write_reg  = 5'd0;
    write_data = 32'd55;
    read_reg_1 = 5'd0;
    read_reg_2 = 5'd7;
    #1;
    check("pending_w0_out1", out_data_1, 32'd0);
    check("pending_w0_out2", out_data_2, 32'd8);
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    #1;
    check("after_w0_out1", out_data_1, 32'd0);

    // Mid-cycle async reset with a pending write to reg 9.
    @(negedge clk);
    read_reg_1 = 5'd2;
    read_reg_2 = 5'd31;
    RegWrite   = 1'b1;
    write_reg  = 5'd9;
    write_data = 32'd77;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out1", out_data_1, 32'd0);
    check("async_rst_out2", out_data_2, 32'd0);
    read_reg_1 = 5'd9;
    #1;
    check("rst_no_bypass", out_data_1, 32'd0);
    @(posedge clk);
    #1;
    check("rst_edge_w9", out_data_1, 32'd0);
    check("rst_edge_r31", out_data_2, 32'd0);

    // Release reset mid-cycle; pending write commits on the next edge.
    @(negedge clk);
    rst        = 1'b0;
    read_reg_1 = 5'd9;
    read_reg_2 = 5'd2;
    #1;
    check("post_rst_r2", out_data_2, 32'd0);
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    #1;
    check("post_rst_w9", out_data_1, 32'd77);
    check("post_rst_r2_after", out_data_2, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_register_file
